mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, word address width; DATA_W, default 16, data word width.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  1  core request; sampled only when ready=1.
REQ-005 SHALL have port we  input  1  1=write, 0=read; latched on accept.
REQ-006 SHALL have port ind  input  1  1=indirect addressing, 0=direct; latched on accept.
REQ-007 SHALL have port addr  input  ADDR_W  core word address; latched on accept.
REQ-008 SHALL have port wdata  input  DATA_W  write data; latched on accept.
REQ-009 SHALL have port ready  output  1  high only in IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  DATA_W  read result; valid from done until the next accepted read.
REQ-012 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-013 SHALL have port mem_addr_mode  output  1  memory indirect-read select.
REQ-014 SHALL have port mem_wr  output  1  memory write strobe; memory writes on its rising edge.
REQ-015 SHALL have port mem_data_in  output  DATA_W  memory write data.
REQ-016 SHALL have port mem_data_out  input  DATA_W  combinational memory read data.

Function
REQ-017 SHALL implement states IDLE, RD, PTR, WR_SETUP, WR_STROBE, WR_HOLD, DONE.
REQ-018 SHALL accept a request on a clk edge where state=IDLE and req=1, latching we, ind, addr and wdata; req in any other state is dropped, not queued.
REQ-019 Read (either ind value): IDLE->RD->DONE->IDLE; in RD drive mem_addr=addr and mem_addr_mode=ind; rdata captures mem_data_out at the end of RD.
REQ-020 Direct write: IDLE->WR_SETUP->WR_STROBE->WR_HOLD->DONE->IDLE.
REQ-021 Indirect write: IDLE->PTR->WR_SETUP->...; in PTR drive mem_addr=addr and mem_addr_mode=0, and capture pointer = mem_data_out[ADDR_W-1:0] at the end of PTR.
REQ-022 Pointer truncation: bits above ADDR_W-1 SHALL be ignored.
REQ-023 In WR_SETUP, WR_STROBE and WR_HOLD, mem_addr (addr or pointer), mem_data_in=wdata and mem_addr_mode=0 SHALL be held stable.
REQ-024 mem_wr=1 only in WR_STROBE, giving exactly one rising edge per write, with one full cycle of address/data setup and one of hold.
REQ-025 mem_wr, mem_addr, mem_addr_mode and mem_data_in SHALL be flop outputs (glitch-free).
REQ-026 Latency from the accept edge to done high SHALL be: read 2 cycles; direct write 4; indirect write 5.
REQ-027 done=1 only in DONE; ready=1 only in IDLE; back-to-back throughput SHALL be one operation per (latency+1) cycles.
REQ-028 Outside an operation, mem_addr_mode=0 and mem_wr=0; mem_addr and mem_data_in keep their last value.

Reset
REQ-029 On rst=1, immediately and asynchronously: state=IDLE, ready=1 after release, done=0, mem_wr=0, mem_addr_mode=0, mem_addr=0, mem_data_in=0, rdata=0, pointer=0.
REQ-030 Reset asserted mid-operation SHALL abort it; no rising edge of mem_wr SHALL occur during reset assertion or on its release.

Structure
REQ-031 State encoding, ADDR_W and DATA_W SHALL live in the shared CPU package/header.
REQ-032 No sub-module; single FSM plus datapath registers.

Verification
REQ-033 Bench SHALL connect the team's behavioural memory model; preload mem[0x005]=0x0123, mem[0x123]=0xBEEF; direct read of 0x005 -> done at +2 cycles, rdata=0x0123.
REQ-034 Indirect read of 0x005 -> rdata=0xBEEF, mem_addr_mode=1 during RD only.
REQ-035 Direct write 0x1234 to 0x010 -> exactly one mem_wr pulse, done at +4 cycles, mem[0x010]=0x1234.
REQ-036 Indirect write 0xCAFE via 0x005 with mem[0x005]=0xFC23 -> pointer 0x023, mem[0x023]=0xCAFE, mem[0x005] unchanged, done at +5 cycles.
REQ-037 Assert rst during WR_SETUP of a write to 0x020 -> no mem_wr edge, mem[0x020] unchanged, ready=1 after release.
REQ-038 Hold req=1 continuously through 3 reads -> each accepted only in IDLE, one done per read, none dropped or duplicated.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared widths and FSM state encoding for the memory access unit.
// Pure declarations: no logic, no latency, no flow control.
package mem_access_unit_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD        = 3'd1,
    ST_PTR       = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_WR_HOLD   = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Core-to-memory sequencer: read 2, direct write 4, indirect write 5 cycles to done.
// Accepts one request only while ready (IDLE); requests in other states are dropped.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = mem_access_unit_pkg::ADDR_W,
  parameter int DATA_W = mem_access_unit_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              ind,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_addr_mode,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t            state, next_state;
  logic              accept;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_d;
  logic              mem_addr_mode_d;
  logic              mem_wr_d;

  assign accept = (state == ST_IDLE) && req;
  assign ready  = (state == ST_IDLE);
  assign done   = (state == ST_DONE);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (req) next_state = we ? (ind ? ST_PTR : ST_WR_SETUP) : ST_RD;
      ST_RD:        next_state = ST_DONE;
      ST_PTR:       next_state = ST_WR_SETUP;
      ST_WR_SETUP:  next_state = ST_WR_STROBE;
      ST_WR_STROBE: next_state = ST_WR_HOLD;
      ST_WR_HOLD:   next_state = ST_DONE;
      ST_DONE:      next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Memory-side signals are registered one state early so they leave flops
  // already valid on entry; mem_addr doubles as the latched address/pointer.
  always_comb begin
    mem_addr_d    = mem_addr;
    mem_data_in_d = mem_data_in;
    if (accept) begin
      mem_addr_d = addr;
      if (we) mem_data_in_d = wdata;
    end else if (state == ST_PTR) begin
      mem_addr_d = mem_data_out[ADDR_W-1:0];
    end
    mem_addr_mode_d = accept && !we && ind;
    mem_wr_d        = (next_state == ST_WR_STROBE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      mem_addr      <= '0;
      mem_data_in   <= '0;
      mem_addr_mode <= 1'b0;
      mem_wr        <= 1'b0;
      rdata         <= '0;
    end else begin
      state         <= next_state;
      mem_addr      <= mem_addr_d;
      mem_data_in   <= mem_data_in_d;
      mem_addr_mode <= mem_addr_mode_d;
      mem_wr        <= mem_wr_d;
      if (state == ST_RD) rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural memory, directed cases, random ops vs reference model.
// Memory writes on the rising edge of mem_wr; indirect reads return mem[mem[addr]].
module tb_mem_access_unit;

  localparam int AW    = mem_access_unit_pkg::ADDR_W;
  localparam int DW    = mem_access_unit_pkg::DATA_W;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, we, ind;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready, done;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_addr_mode, mem_wr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  logic          bd_wr = 1'b0;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  int            wr_edges = 0;
  logic [AW-1:0] last_wr_addr = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .ind(ind), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .mem_addr(mem_addr),
    .mem_addr_mode(mem_addr_mode), .mem_wr(mem_wr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // Behavioural memory: combinational read, write on mem_wr rising edge, plus backdoor preload.
  assign mem_data_out = mem_addr_mode ? mem[mem[mem_addr][AW-1:0]] : mem[mem_addr];

  always @(posedge mem_wr or posedge bd_wr) begin
    if (bd_wr) begin
      mem[bd_addr] = bd_data;
    end else begin
      mem[mem_addr] = mem_data_in;
      last_wr_addr  = mem_addr;
      wr_edges++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_addr = a;
    bd_data = d;
    bd_wr   = 1'b1;
    #1 bd_wr = 1'b0;
    #1;
    ref_mem[a] = d;
  endtask

  // One operation against the reference model: target word, read value and latency
  // come straight from the rules, not from the DUT's state sequence.
  task automatic do_op(input string tag, input logic op_we, input logic op_ind,
                       input logic [AW-1:0] op_addr, input logic [DW-1:0] op_wdata);
    int            n, cyc, mode_cnt, edges0, exp_lat;
    bit            got_done;
    logic [AW-1:0] tgt;
    logic [DW-1:0] exp_rd;
    exp_lat = !op_we ? 2 : (op_ind ? 5 : 4);
    tgt     = op_ind ? ref_mem[op_addr][AW-1:0] : op_addr;
    exp_rd  = ref_mem[tgt];
    @(negedge clk);
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(ready), 32'd1);
    req = 1'b1; we = op_we; ind = op_ind; addr = op_addr; wdata = op_wdata;
    edges0 = wr_edges; cyc = 0; mode_cnt = 0; got_done = 1'b0;
    while (!got_done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        req = 1'b0; we = 1'($urandom); ind = 1'($urandom);
        addr = AW'($urandom); wdata = DW'($urandom);
      end
      if (mem_addr_mode) mode_cnt++;
      if (done) got_done = 1'b1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_mode_cycles"}, 32'(mode_cnt), (!op_we && op_ind) ? 32'd1 : 32'd0);
    check({tag, "_wr_edges"}, 32'(wr_edges - edges0), op_we ? 32'd1 : 32'd0);
    if (op_we) begin
      check({tag, "_wr_addr"}, 32'(last_wr_addr), 32'(tgt));
      ref_mem[tgt] = op_wdata;
    end else begin
      check({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
    end
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {30'd0, done, ready}, 32'd1);
  endtask

  initial begin
    int            accepts, dones, last_acc, bad_spacing, bad_rd, edges0, diffs;
    logic [DW-1:0] pre;
    rst = 1'b1; req = 1'b0; we = 1'b0; ind = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < DEPTH; i++) bd_write(AW'(i), DW'($urandom));
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mode", 32'(mem_addr_mode), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data_in", 32'(mem_data_in), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_wr_edges", 32'(wr_edges), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("rst_release_ready", 32'(ready), 32'd1);

    bd_write(AW'('h005), 16'h0123);
    bd_write(AW'('h123), 16'hBEEF);
    do_op("dir_rd", 1'b0, 1'b0, AW'('h005), 16'h0);
    check("dir_rd_value", 32'(rdata), 32'h0123);
    do_op("ind_rd", 1'b0, 1'b1, AW'('h005), 16'h0);
    check("ind_rd_value", 32'(rdata), 32'hBEEF);
    do_op("dir_wr", 1'b1, 1'b0, AW'('h010), 16'h1234);
    check("dir_wr_mem", 32'(mem['h010]), 32'h1234);

    bd_write(AW'('h005), 16'hFC23);
    do_op("ind_wr", 1'b1, 1'b1, AW'('h005), 16'hCAFE);
    check("ind_wr_ptr", 32'(last_wr_addr), 32'h023);
    check("ind_wr_mem", 32'(mem['h023]), 32'hCAFE);
    check("ind_wr_ptr_word", 32'(mem['h005]), 32'hFC23);

    // Reset while in WR_SETUP of a write to 0x020
    @(negedge clk);
    pre = mem['h020];
    edges0 = wr_edges;
    req = 1'b1; we = 1'b1; ind = 1'b0; addr = AW'('h020); wdata = 16'h5555;
    @(posedge clk);
    #1 req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_mem_wr", 32'(mem_wr), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("abort_ready", 32'(ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("abort_wr_edges", 32'(wr_edges - edges0), 32'd0);
    check("abort_mem_kept", 32'(mem['h020]), 32'(pre));

    // req held high through three reads
    bd_write(AW'('h005), 16'h0123);
    @(negedge clk);
    req = 1'b1; we = 1'b0; ind = 1'b0; addr = AW'('h005);
    accepts = 0; dones = 0; last_acc = -1; bad_spacing = 0; bad_rd = 0;
    for (int i = 0; i < 14; i++) begin
      if (accepts == 3) req = 1'b0;
      if (ready && req) begin
        accepts++;
        if (last_acc >= 0 && i - last_acc != 3) bad_spacing++;
        last_acc = i;
      end
      if (done) begin
        dones++;
        if (rdata !== 16'h0123) bad_rd++;
      end
      @(negedge clk);
    end
    req = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd3);
    check("b2b_dones", 32'(dones), 32'd3);
    check("b2b_spacing", 32'(bad_spacing), 32'd0);
    check("b2b_rdata", 32'(bad_rd), 32'd0);

    for (int k = 0; k < 40; k++)
      do_op("rand", 1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));

    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("final_mem_diffs", 32'(diffs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
